// File: rtl/rvj1_ram_responder.sv
// Single-port word RAM that answers the core's memory request/response protocol.
// At most one transaction is in flight; the response appears LATENCY cycles after acceptance.
module rvj1_ram_responder #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      NBYTES    = 4,
  parameter int unsigned      MEM_WORDS = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR = '0,
  parameter int unsigned      LATENCY   = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_data_i,
  input  logic [NBYTES-1:0] req_strobe_i,
  input  logic              req_write_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_error_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_error_q;

  logic [XLEN-1:0]   mem [MEM_WORDS];

  logic [XLEN-1:0]   offset;
  logic [XLEN-1:0]   word_off;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              accept;

  // Address decode: subtraction wraps, so addresses below the base land far out of range.
  assign offset       = req_addr_i - BASE_ADDR;
  assign word_off     = offset >> 2;
  assign idx          = word_off[IDX_W-1:0];
  assign misaligned   = |req_addr_i[1:0];
  assign out_of_range = (word_off >= XLEN'(MEM_WORDS));
  assign fault        = misaligned | out_of_range;

  // Ready is gated by reset so it reads 0 during reset and 1 right after release.
  assign req_ready_o  = rstn_i & (state_q == ST_IDLE);
  assign accept       = req_valid_i & req_ready_o;

  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_error_o  = rsp_error_q;

  // Byte-masked write on the acceptance edge; memory is intentionally not reset.
  always_ff @(posedge clk_i) begin : mem_write
    if (accept && req_write_i && !fault) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (req_strobe_i[b]) begin
          mem[idx][8*b +: 8] <= req_data_i[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with response payload captured at acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin : fsm
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rsp_error_q <= fault;
            rsp_data_q  <= (req_write_i || fault) ? '0 : mem[idx];
            if (LATENCY <= 1) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvj1_ram_responder.sv
// Bench for rvj1_ram_responder: three instances (LATENCY 1/3/4, two base addresses),
// directed vector table plus randomized traffic against an array-based memory model.
module tb_rvj1_ram_responder;

  localparam int unsigned WORDS = 64;

  logic        clk = 1'b0;
  logic        rstn        [3];
  logic [31:0] req_addr    [3];
  logic [31:0] req_data    [3];
  logic [3:0]  req_strobe  [3];
  logic        req_write   [3];
  logic        req_valid   [3];
  logic        req_ready   [3];
  logic [31:0] rsp_data    [3];
  logic        rsp_error   [3];
  logic        rsp_valid   [3];
  logic        rsp_ready   [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [3][WORDS];

  always #5 clk = ~clk;

  rvj1_ram_responder #(.XLEN(32), .NBYTES(4), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rstn_i(rstn[0]), .req_addr_i(req_addr[0]), .req_data_i(req_data[0]),
    .req_strobe_i(req_strobe[0]), .req_write_i(req_write[0]), .req_valid_i(req_valid[0]),
    .req_ready_o(req_ready[0]), .rsp_data_o(rsp_data[0]), .rsp_error_o(rsp_error[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]));

  rvj1_ram_responder #(.XLEN(32), .NBYTES(4), .MEM_WORDS(WORDS), .BASE_ADDR(32'h1000), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rstn_i(rstn[1]), .req_addr_i(req_addr[1]), .req_data_i(req_data[1]),
    .req_strobe_i(req_strobe[1]), .req_write_i(req_write[1]), .req_valid_i(req_valid[1]),
    .req_ready_o(req_ready[1]), .rsp_data_o(rsp_data[1]), .rsp_error_o(rsp_error[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]));

  rvj1_ram_responder #(.XLEN(32), .NBYTES(4), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rstn_i(rstn[2]), .req_addr_i(req_addr[2]), .req_data_i(req_data[2]),
    .req_strobe_i(req_strobe[2]), .req_write_i(req_write[2]), .req_valid_i(req_valid[2]),
    .req_ready_o(req_ready[2]), .rsp_data_o(rsp_data[2]), .rsp_error_o(rsp_error[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]));

  typedef struct {
    int          u;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        wr;
    logic [31:0] exp_d;
    logic        exp_e;
    int          hold;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] base_of(input int u);
    return (u == 1) ? 32'h1000 : 32'h0;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 3 : 4);
  endfunction

  function automatic logic faults(input int u, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(u);
    return (a[1:0] != 2'b00) || ((off / 4) >= WORDS);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction: request, latency/busy checks, optional stall, handshake.
  task automatic do_txn(input int u, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic wr, input logic [31:0] exp_d,
                        input logic exp_e, input int hold);
    int cyc;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[u]), 32'd1);
    req_addr[u] = addr; req_data[u] = data; req_strobe[u] = strb;
    req_write[u] = wr; req_valid[u] = 1'b1; rsp_ready[u] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // A conflicting write is held on the request port while busy; it must be ignored.
    req_addr[u]   = base_of(u) + 32'(4 * $urandom_range(0, WORDS - 1));
    req_data[u]   = $urandom;
    req_strobe[u] = 4'hF;
    req_write[u]  = 1'b1;
    cyc = 1;
    while (!rsp_valid[u] && cyc < 16) begin
      chk("ready_busy", 32'(req_ready[u]), 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat_of(u)));
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(rsp_valid[u]), 32'd1);
      chk("hold_data", rsp_data[u], exp_d);
      chk("hold_err", 32'(rsp_error[u]), 32'(exp_e));
      chk("ready_resp", 32'(req_ready[u]), 32'd0);
      @(negedge clk);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    chk("rsp_valid", 32'(rsp_valid[u]), 32'd1);
    chk("rsp_data", rsp_data[u], exp_d);
    chk("rsp_err", 32'(rsp_error[u]), 32'(exp_e));
    @(posedge clk);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[u]), 32'd0);
    chk("ready_after", 32'(req_ready[u]), 32'd1);
    if (wr && !faults(u, addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[u][(addr - base_of(u)) >> 2][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic model_txn(input int u, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic wr, input int hold);
    logic        e;
    logic [31:0] d;
    e = faults(u, addr);
    d = (wr || e) ? 32'h0 : mdl[u][(addr - base_of(u)) >> 2];
    do_txn(u, addr, data, strb, wr, d, e, hold);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;

    for (int u = 0; u < 3; u++) begin
      rstn[u] = 1'b1; req_addr[u] = '0; req_data[u] = '0; req_strobe[u] = '0;
      req_write[u] = 1'b0; req_valid[u] = 1'b0; rsp_ready[u] = 1'b0;
    end
    #1;
    for (int u = 0; u < 3; u++) rstn[u] = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_ready", 32'(req_ready[u]), 32'd0);
      chk("rst_valid", 32'(rsp_valid[u]), 32'd0);
      chk("rst_data", rsp_data[u], 32'd0);
      chk("rst_err", 32'(rsp_error[u]), 32'd0);
    end
    for (int u = 0; u < 3; u++) rstn[u] = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) chk("ready_release", 32'(req_ready[u]), 32'd1);

    // Fill every word so all later reads have a known model value.
    for (int u = 0; u < 3; u++)
      for (int w = 0; w < int'(WORDS); w++)
        model_txn(u, base_of(u) + 32'(4 * w), $urandom, 4'hF, 1'b1, 0);

    tbl.push_back('{0, 32'h10,  32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 0});
    tbl.push_back('{0, 32'h10,  32'h11223344, 4'h5, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDE22BE44, 1'b0, 0});
    tbl.push_back('{0, 32'h0,   32'hA5A5A5A5, 4'hF, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{0, 32'h2,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 0});
    tbl.push_back('{0, 32'h2,   32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        1'b1, 0});
    tbl.push_back('{0, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        1'b1, 0});
    tbl.push_back('{0, 32'h100, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 0});
    tbl.push_back('{0, 32'h0,   32'h0,        4'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 0});
    tbl.push_back('{0, 32'h14,  32'h12345678, 4'hF, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{0, 32'h14,  32'hFFFFFFFF, 4'h0, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{0, 32'h14,  32'h0,        4'h0, 1'b0, 32'h12345678, 1'b0, 0});
    tbl.push_back('{1, 32'h0FFC, 32'h0,       4'h0, 1'b0, 32'h0,        1'b1, 0});
    tbl.push_back('{1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0,       1'b0, 2});
    tbl.push_back('{1, 32'h1000, 32'h0,       4'h0, 1'b0, 32'hCAFEF00D, 1'b0, 5});
    tbl.push_back('{1, 32'h10FC, 32'h5A5A0001, 4'hF, 1'b1, 32'h0,       1'b0, 0});
    tbl.push_back('{1, 32'h10FC, 32'h0,       4'h0, 1'b0, 32'h5A5A0001, 1'b0, 1});
    tbl.push_back('{1, 32'h1100, 32'h0,       4'h0, 1'b0, 32'h0,        1'b1, 0});
    tbl.push_back('{2, 32'h0C,  32'h01020304, 4'hF, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{2, 32'h0C,  32'hAABBCCDD, 4'hA, 1'b1, 32'h0,        1'b0, 0});
    tbl.push_back('{2, 32'h0C,  32'h0,        4'h0, 1'b0, 32'hAA02CC04, 1'b0, 3});
    foreach (tbl[i])
      do_txn(tbl[i].u, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].wr,
             tbl[i].exp_d, tbl[i].exp_e, tbl[i].hold);

    // Reset in the middle of a LATENCY=4 write: write sticks, response is dropped.
    @(negedge clk);
    req_addr[2] = 32'h20; req_data[2] = 32'h0BADF00D; req_strobe[2] = 4'hF;
    req_write[2] = 1'b1; req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("wait_valid", 32'(rsp_valid[2]), 32'd0);
    #2 rstn[2] = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready[2]), 32'd0);
    chk("midrst_valid", 32'(rsp_valid[2]), 32'd0);
    chk("midrst_data", rsp_data[2], 32'd0);
    chk("midrst_err", 32'(rsp_error[2]), 32'd0);
    repeat (2) @(negedge clk);
    rstn[2] = 1'b1;
    #1;
    chk("midrst_release", 32'(req_ready[2]), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no_ghost_rsp", 32'(rsp_valid[2]), 32'd0);
    end
    mdl[2][8] = 32'h0BADF00D;
    do_txn(2, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b0, 0);

    // Randomized traffic across all instances.
    for (int n = 0; n < 150; n++) begin
      for (int u = 0; u < 3; u++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0:       a = base_of(u) + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
          1:       a = base_of(u) + 32'(4 * $urandom_range(WORDS, WORDS + 16));
          2:       a = base_of(u) - 32'(4 * $urandom_range(1, 4));
          default: a = base_of(u) + 32'(4 * $urandom_range(0, WORDS - 1));
        endcase
        model_txn(u, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvj1_ram_responder.md
RVJ1_RAM_RESPONDER -- requirements
Module: rvj1_ram_responder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clk_i and rstn_i.
REQ-002 Parameter XLEN, default 32: data and address width.
REQ-003 Parameter NBYTES, default 4: byte-strobe width, equal to XLEN/8.
REQ-004 Parameter MEM_WORDS, default 1024: memory depth in XLEN-bit words.
REQ-005 Parameter BASE_ADDR, default 0: byte address of word 0.
REQ-006 Parameter LATENCY, default 1, legal range 1..4: number of cycles from request acceptance to rsp_valid_o assertion.
REQ-007 clk_i  in  1  clock; all state is updated on the rising edge.
REQ-008 rstn_i  in  1  asynchronous active-low reset.
REQ-009 req_addr_i  in  XLEN  byte address of the request.
REQ-010 req_data_i  in  XLEN  write data.
REQ-011 req_strobe_i  in  NBYTES  byte-enables for writes.
REQ-012 req_write_i  in  1  1 = write, 0 = read.
REQ-013 req_valid_i  in  1  a request is present.
REQ-014 req_ready_o  out  1  the block can accept a request.
REQ-015 rsp_data_o  out  XLEN  read data; 0 for writes and errors.
REQ-016 rsp_error_o  out  1  the request faulted.
REQ-017 rsp_valid_o  out  1  a response is present.
REQ-018 rsp_ready_i  in  1  the initiator accepts the response.

Function
REQ-019 The block SHALL be the responder end of the core's memory request/response protocol, with one outstanding transaction at most.
REQ-020 The FSM SHALL have three states:
- IDLE: req_ready_o=1.
- WAIT: latency counter running.
- RESP: rsp_valid_o=1.
REQ-021 Acceptance SHALL occur on a rising edge where req_valid_i=1 and req_ready_o=1.
REQ-022 On acceptance the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT with the counter loaded to LATENCY-1.
REQ-023 In WAIT the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-024 rsp_valid_o SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-025 In RESP, rsp_valid_o, rsp_data_o and rsp_error_o SHALL stay stable until an edge with rsp_ready_i=1, after which the FSM SHALL return to IDLE.
REQ-026 req_ready_o SHALL be low in WAIT and in RESP; the next request is accepted no earlier than the cycle after the response handshake.
REQ-027 A request SHALL fault when either:
- req_addr_i[1:0] != 0, or
- req_addr_i is outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS).
REQ-028 A faulting request SHALL return rsp_error_o=1 and rsp_data_o=0, and SHALL NOT modify memory.
REQ-029 Word index SHALL be (req_addr_i - BASE_ADDR) >> 2, computed modulo 2^XLEN so that an address below BASE_ADDR wraps and is detected as out of range.
REQ-030 On the acceptance edge, a non-faulting write SHALL update only the bytes whose strobe bit is 1, and SHALL respond with rsp_data_o=0 and rsp_error_o=0.
REQ-031 A write with an all-zero strobe SHALL leave memory unchanged and SHALL NOT fault.
REQ-032 A non-faulting read SHALL capture the memory word on the acceptance edge and return it in RESP with rsp_error_o=0.
REQ-033 A read accepted after a completed write to the same word SHALL return the updated data.
REQ-034 Request inputs SHALL be ignored whenever req_ready_o=0.

Reset
REQ-035 While rstn_i=0, regardless of clk_i, the outputs SHALL be: req_ready_o=0, rsp_valid_o=0, rsp_error_o=0, rsp_data_o=0.
REQ-036 While rstn_i=0 the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-037 req_ready_o SHALL be 1 in the first cycle after rstn_i deasserts.
REQ-038 Memory contents SHALL NOT be reset.
REQ-039 A reset asserted in WAIT or RESP SHALL discard the pending response; no rsp_valid_o SHALL follow.
REQ-040 A write accepted before a reset SHALL remain committed.

Verification
REQ-041 LATENCY=1: write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10 -> write response has data 0, error 0; read response is 0xDEADBEEF, error 0, rsp_valid_o high one cycle after each acceptance.
REQ-042 Start with word 0x10 = 0xDEADBEEF; write 0x11223344 to 0x10 with strobe 0b0101 -> a subsequent read returns 0xDE22BE44.
REQ-043 LATENCY=3, rsp_ready_i held low for 5 cycles -> rsp_valid_o rises 3 cycles after acceptance, outputs stay stable, req_ready_o stays low throughout; req_ready_o returns to 1 the cycle after the handshake.
REQ-044 Requests to addresses 0x2 (misaligned) and 4*MEM_WORDS (out of range, BASE_ADDR=0) -> rsp_error_o=1 and rsp_data_o=0; a write to either address leaves memory unchanged.
REQ-045 BASE_ADDR=0x1000, read of 0x0FFC -> rsp_error_o=1 (address wrap detected as out of range).
REQ-046 Assert rstn_i during WAIT with LATENCY=4 -> outputs go to reset values immediately, no response appears afterwards, and req_ready_o=1 in the first cycle after release.
